// File: rtl/spi_master_device.sv
// Byte-wide SPI master with register bus access: CONFIG / STATUS / DATA.
// Supports all four SPI modes, a programmable SCK half-period divider,
// automatic or firmware-controlled chip select, and a completion interrupt.
`timescale 1ns/1ps
module spi_master_device #(
  parameter int unsigned CLOCK_DIV_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs,
  output logic        spi_oe,
  output logic        irq
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned EDGE_W  = 5;
  localparam int unsigned CFG_TOP = 8 + CLOCK_DIV_WIDTH;
  localparam logic [3:0] ADDR_CONFIG = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_DATA   = 4'h8;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(16);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD
  } state_t;

  state_t state_q, state_d;

  logic                       enable_q, cpha_q, cpol_q, cs_manual_q, cs_assert_q, irq_en_q;
  logic                       enable_d, cpha_d, cpol_d, cs_manual_d, cs_assert_d, irq_en_d;
  logic [CLOCK_DIV_WIDTH-1:0] clk_div_q, clk_div_d;
  logic [CLOCK_DIV_WIDTH-1:0] div_cnt_q;
  logic [EDGE_W-1:0]          edge_cnt_q;
  logic [DATA_W-1:0]          tx_shift_q, rx_shift_q, rx_data_q;
  logic                       rx_valid_q, rx_valid_d;
  logic                       sck_q, sck_d, mosi_q, cs_q, cs_d, irq_q;

  logic cfg_wr_c, cfg_upd_c, data_wr_c, data_rd_c, busy_c, start_c, hp_end_c;
  logic toggle_c, done_c, leading_c, trailing_c, sample_c, shift_c;
  logic unused_wdata;

  // Bus strobe decode and half-period tick
  assign cfg_wr_c  = bus_sel & bus_we & (bus_addr == ADDR_CONFIG);
  assign data_wr_c = bus_sel & bus_we & (bus_addr == ADDR_DATA);
  assign data_rd_c = bus_sel & ~bus_we & (bus_addr == ADDR_DATA);
  assign busy_c    = (state_q != ST_IDLE);
  assign cfg_upd_c = cfg_wr_c & ~busy_c;
  assign start_c   = data_wr_c & enable_q & ~busy_c;
  assign hp_end_c  = busy_c & (div_cnt_q == clk_div_q);

  // A toggle away from CPOL is a leading edge; CPHA picks which edge samples
  assign leading_c  = toggle_c & (sck_q == cpol_q);
  assign trailing_c = toggle_c & (sck_q != cpol_q);
  assign sample_c   = cpha_q ? trailing_c : leading_c;
  assign shift_c    = cpha_q ? leading_c  : trailing_c;

  assign unused_wdata = ^bus_wdata[31:CFG_TOP];

  // Next-state, next config and next registered-output values
  always_comb begin
    state_d     = state_q;
    toggle_c    = 1'b0;
    done_c      = 1'b0;
    enable_d    = enable_q;
    cpha_d      = cpha_q;
    cpol_d      = cpol_q;
    cs_manual_d = cs_manual_q;
    cs_assert_d = cs_assert_q;
    irq_en_d    = irq_en_q;
    clk_div_d   = clk_div_q;
    rx_valid_d  = rx_valid_q;
    sck_d       = sck_q;
    cs_d        = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start_c) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (hp_end_c) begin
          toggle_c = 1'b1;
          state_d  = ST_XFER;
        end
      end
      ST_XFER: begin
        if (hp_end_c) begin
          if (edge_cnt_q == LAST_EDGE) state_d = ST_HOLD;
          else                         toggle_c = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hp_end_c) begin
          state_d = ST_IDLE;
          done_c  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cfg_upd_c) begin
      enable_d    = bus_wdata[0];
      cpha_d      = bus_wdata[1];
      cpol_d      = bus_wdata[2];
      cs_manual_d = bus_wdata[3];
      irq_en_d    = bus_wdata[5];
      clk_div_d   = bus_wdata[8 +: CLOCK_DIV_WIDTH];
    end
    if (cfg_wr_c) cs_assert_d = bus_wdata[4];

    // Fresh completion data beats a same-cycle DATA read
    if (done_c)         rx_valid_d = 1'b1;
    else if (data_rd_c) rx_valid_d = 1'b0;

    if (!busy_c)       sck_d = cpol_d;
    else if (toggle_c) sck_d = ~sck_q;

    if (!enable_d)       cs_d = 1'b1;
    else if (cs_manual_d) cs_d = ~cs_assert_d;
    else                  cs_d = (state_d == ST_IDLE);
  end

  // State, configuration and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      enable_q    <= 1'b0;
      cpha_q      <= 1'b0;
      cpol_q      <= 1'b0;
      cs_manual_q <= 1'b0;
      cs_assert_q <= 1'b0;
      irq_en_q    <= 1'b0;
      clk_div_q   <= '0;
      rx_valid_q  <= 1'b0;
      sck_q       <= 1'b0;
      cs_q        <= 1'b1;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      cpha_q      <= cpha_d;
      cpol_q      <= cpol_d;
      cs_manual_q <= cs_manual_d;
      cs_assert_q <= cs_assert_d;
      irq_en_q    <= irq_en_d;
      clk_div_q   <= clk_div_d;
      rx_valid_q  <= rx_valid_d;
      sck_q       <= sck_d;
      cs_q        <= cs_d;
      irq_q       <= rx_valid_d & irq_en_d;
    end
  end

  // Divider, edge counter and TX/RX shift registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      mosi_q     <= 1'b0;
    end else begin
      if (!busy_c || hp_end_c) div_cnt_q <= '0;
      else                     div_cnt_q <= div_cnt_q + 1'b1;

      if (start_c)       edge_cnt_q <= '0;
      else if (toggle_c) edge_cnt_q <= edge_cnt_q + 1'b1;

      if (start_c) begin
        if (cpha_q) begin
          tx_shift_q <= bus_wdata[DATA_W-1:0];
        end else begin
          mosi_q     <= bus_wdata[DATA_W-1];
          tx_shift_q <= {bus_wdata[DATA_W-2:0], 1'b0};
        end
      end else if (shift_c) begin
        mosi_q     <= tx_shift_q[DATA_W-1];
        tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
      end

      if (start_c)       rx_shift_q <= '0;
      else if (sample_c) rx_shift_q <= {rx_shift_q[DATA_W-2:0], spi_miso};

      if (done_c) rx_data_q <= rx_shift_q;
    end
  end

  // Register read mux, combinational from the address
  always_comb begin
    bus_rdata = '0;
    case (bus_addr)
      ADDR_CONFIG: begin
        bus_rdata[0] = enable_q;
        bus_rdata[1] = cpha_q;
        bus_rdata[2] = cpol_q;
        bus_rdata[3] = cs_manual_q;
        bus_rdata[4] = cs_assert_q;
        bus_rdata[5] = irq_en_q;
        bus_rdata[8 +: CLOCK_DIV_WIDTH] = clk_div_q;
      end
      ADDR_STATUS: begin
        bus_rdata[0] = busy_c;
        bus_rdata[1] = rx_valid_q;
      end
      ADDR_DATA: bus_rdata[DATA_W-1:0] = rx_data_q;
      default:   bus_rdata = '0;
    endcase
  end

  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;
  assign spi_cs   = cs_q;
  assign spi_oe   = enable_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_spi_master_device.sv
// Bench for spi_master_device: behavioural SPI slave, table vectors,
// hand-written corner sequences and randomized transfers.
`timescale 1ns/1ps
module tb_spi_master_device;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_sel, bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        spi_sck, spi_mosi, spi_cs, spi_oe, irq;
  logic        miso_r;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] EN = 32'h01, CPHA = 32'h02, CPOL = 32'h04;
  localparam logic [31:0] MAN = 32'h08, ASSERT = 32'h10, IRQEN = 32'h20;

  spi_master_device dut (
    .clk(clk), .rst(rst), .bus_sel(bus_sel), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(miso_r),
    .spi_cs(spi_cs), .spi_oe(spi_oe), .irq(irq)
  );

  always #12.5 clk = ~clk;

  // Behavioural SPI slave for the currently configured mode
  logic       tb_cpol = 1'b0, tb_cpha = 1'b0;
  logic [7:0] s_pre = 8'h00, s_tx = 8'h00, s_rx = 8'h00;
  int         s_cnt = 0, cs_falls = 0;
  realtime    cs_fall_time = 0.0;
  realtime    edges[$];

  always @(negedge spi_cs) begin
    cs_falls++;
    cs_fall_time = $realtime;
    s_tx  = s_pre;
    s_rx  = 8'h00;
    s_cnt = 0;
    if (!tb_cpha) miso_r = s_tx[7];
  end

  always @(spi_sck) begin
    if (spi_cs === 1'b0 && spi_oe === 1'b1) begin
      edges.push_back($realtime);
      if ((spi_sck != tb_cpol) ^ tb_cpha) begin
        s_rx = {s_rx[6:0], spi_mosi};
        s_cnt++;
      end else if (tb_cpha) begin
        miso_r = s_tx[7];
        s_tx   = {s_tx[6:0], 1'b0};
      end else begin
        s_tx   = {s_tx[6:0], 1'b0};
        miso_r = s_tx[7];
      end
    end
  end

  function automatic logic [31:0] divf(input int d);
    return 32'(d) << 8;
  endfunction

  // Reference: SETUP + 16 SCK half periods + HOLD, each clk_div+1 cycles
  function automatic int exp_busy(input int d);
    return 18 * (d + 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input real v, input real lo, input real hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s: got %0.1f ns, expected %0.1f..%0.1f ns", name, v, lo, hi);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_sel = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
    #1 d = bus_rdata;
    @(negedge clk);
    bus_sel = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [31:0] d);
    bus_addr = a;
    #1 d = bus_rdata;
  endtask

  // Counts cycles with busy=1 by polling STATUS; bounded
  task automatic wait_idle(output int cyc);
    cyc = 0;
    bus_addr = 4'h4;
    #1;
    while (bus_rdata[0] === 1'b1 && cyc < 20000) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    if (cyc >= 20000) chk("busy_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic start_xfer(input logic [31:0] cfg, input logic [7:0] tx, input logic [7:0] pre);
    tb_cpol = cfg[2];
    tb_cpha = cfg[1];
    s_pre   = pre;
    bus_write(4'h0, cfg);
    edges.delete();
    cs_falls = 0;
    s_cnt    = 0;
    s_rx     = 8'h00;
    bus_write(4'h8, {24'h0, tx});
  endtask

  task automatic chk_edges(input string name, input int div);
    real half;
    half = 25.0 * real'(div + 1);
    chk({name, "_edges"}, 32'(edges.size()), 32'd16);
    if (edges.size() >= 3) begin
      chk_rng({name, "_half1"}, edges[1] - edges[0], half - 5.0, half + 5.0);
      chk_rng({name, "_half2"}, edges[2] - edges[1], half - 5.0, half + 5.0);
      chk_rng({name, "_period"}, edges[2] - edges[0], 2.0 * half - 10.0, 2.0 * half + 10.0);
    end
  endtask

  typedef struct {
    logic [31:0] cfg;
    int          div;
    logic [7:0]  tx;
    logic [7:0]  pre;
    logic [7:0]  exp_slave;
    logic [7:0]  exp_rx;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] d;
    int cyc;

    vecs[0] = '{EN | divf(7),               7, 8'h1F, 8'hC5, 8'h1F, 8'hC5, 144};
    vecs[1] = '{EN | CPHA | divf(7),        7, 8'h1F, 8'h5A, 8'h1F, 8'h5A, 144};
    vecs[2] = '{EN | CPHA | divf(7),        7, 8'h83, 8'hE7, 8'h83, 8'hE7, 144};
    vecs[3] = '{EN | divf(7),               7, 8'h9B, 8'h64, 8'h9B, 8'h64, 144};
    vecs[4] = '{EN | CPOL | divf(3),        3, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 72};
    vecs[5] = '{EN | CPOL | CPHA | divf(0), 0, 8'h01, 8'h80, 8'h01, 8'h80, 18};

    rst = 1'b1; bus_sel = 1'b0; bus_we = 1'b0; bus_addr = 4'h0; bus_wdata = '0; miso_r = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    peek(4'h0, d); chk("rst_config", d, 32'h0);
    peek(4'h4, d); chk("rst_status", d, 32'h0);
    peek(4'h8, d); chk("rst_data", d, 32'h0);
    chk("rst_pins", {spi_sck, spi_mosi, spi_cs, irq, spi_oe}, 5'b00100);

    // DATA write with enable=0 is ignored
    bus_write(4'h8, 32'h55);
    peek(4'h4, d); chk("dis_busy", d, 32'h0);
    chk("dis_cs", spi_cs, 1'b1);

    // Mode 0: busy polling, ignored writes while busy
    start_xfer(EN | IRQEN | divf(7), 8'h1F, 8'hC5);
    repeat (20) @(negedge clk);
    peek(4'h4, d); chk("m0_busy", d[0], 1'b1);
    bus_write(4'h8, 32'hFF);
    bus_write(4'h0, EN | CPOL | ASSERT | divf(3));
    wait_idle(cyc);
    peek(4'h4, d); chk("m0_status_done", d, 32'h2);
    chk("m0_irq", irq, 1'b1);
    chk("m0_slave", s_rx, 8'h1F);
    chk("m0_edges", 32'(edges.size()), 32'd16);
    peek(4'h0, d); chk("m0_cfg_locked", d, EN | IRQEN | ASSERT | divf(7));
    bus_read(4'h8, d); chk("m0_data", d, 32'hC5);
    peek(4'h4, d); chk("m0_rxv_clear", d, 32'h0);
    chk("m0_irq_clear", irq, 1'b0);
    repeat (300) @(negedge clk);
    chk("m0_one_byte", 32'(cs_falls), 32'd1);
    chk("m0_bits", 32'(s_cnt), 32'd8);

    // Completion and DATA read in the same cycle
    start_xfer(EN | divf(1), 8'h3C, 8'h96);
    repeat (exp_busy(1) - 1) @(negedge clk);
    peek(4'h4, d); chk("sim_busy_last", d[0], 1'b1);
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 4'h8;
    @(negedge clk);
    bus_sel = 1'b0;
    peek(4'h4, d); chk("sim_rxv_kept", d, 32'h2);
    bus_read(4'h8, d); chk("sim_data", d, 32'h96);
    peek(4'h4, d); chk("sim_rxv_clear", d, 32'h0);
    chk("sim_slave", s_rx, 8'h3C);

    // Manual chip select
    tb_cpol = 1'b0; tb_cpha = 1'b0; s_pre = 8'h5E;
    bus_write(4'h0, EN | MAN | ASSERT | divf(7));
    chk("man_cs_low", spi_cs, 1'b0);
    edges.delete();
    bus_write(4'h8, 32'hA3);
    wait_idle(cyc);
    chk("man_cs_first", (edges.size() > 0 && cs_fall_time < edges[0]), 1'b1);
    chk("man_slave", s_rx, 8'hA3);
    chk("man_cs_held", spi_cs, 1'b0);
    bus_read(4'h8, d); chk("man_data", d, 32'h5E);
    bus_write(4'h0, EN | MAN | divf(7));
    chk("man_cs_high", spi_cs, 1'b1);

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      start_xfer(vecs[i].cfg, vecs[i].tx, vecs[i].pre);
      wait_idle(cyc);
      chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      chk($sformatf("vec%0d_slave", i), s_rx, vecs[i].exp_slave);
      chk($sformatf("vec%0d_idle", i), {spi_sck, spi_cs}, {vecs[i].cfg[2], 1'b1});
      chk_edges($sformatf("vec%0d", i), vecs[i].div);
      peek(4'h4, d); chk($sformatf("vec%0d_rxv", i), d, 32'h2);
      bus_read(4'h8, d); chk($sformatf("vec%0d_data", i), d, {24'h0, vecs[i].exp_rx});
    end

    // Randomized transfers against the reference rules
    for (int i = 0; i < 12; i++) begin
      int div;
      logic [31:0] cfg;
      logic [7:0] tx, pre;
      div = int'($urandom_range(0, 4));
      cfg = EN | divf(div);
      if ($urandom_range(0, 1) == 1) cfg = cfg | CPHA;
      if ($urandom_range(0, 1) == 1) cfg = cfg | CPOL;
      if ($urandom_range(0, 1) == 1) cfg = cfg | IRQEN;
      tx  = 8'($urandom);
      pre = 8'($urandom);
      start_xfer(cfg, tx, pre);
      wait_idle(cyc);
      chk($sformatf("rnd%0d_cycles", i), 32'(cyc), 32'(exp_busy(div)));
      chk($sformatf("rnd%0d_slave", i), s_rx, tx);
      chk($sformatf("rnd%0d_edges", i), 32'(edges.size()), 32'd16);
      chk($sformatf("rnd%0d_irq", i), irq, cfg[5]);
      bus_read(4'h8, d); chk($sformatf("rnd%0d_data", i), d, {24'h0, pre});
      chk($sformatf("rnd%0d_irq_clear", i), irq, 1'b0);
    end

    // Reset mid-byte
    start_xfer(EN | divf(7), 8'h77, 8'h11);
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_pins", {spi_cs, spi_sck, spi_oe, irq}, 4'b1000);
    peek(4'h4, d); chk("rstmid_status", d, 32'h0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    peek(4'h4, d); chk("rstmid_no_rxv", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
